// File: rtl/lr35902_timer_pkg.sv
// Shared constants and types for the DMG timer block (DIV/TIMA/TMA/TAC at 0xff04-0xff07).
package lr35902_pkg;

    // Register index on the local address bus
    localparam logic [1:0] TIM_DIV  = 2'd0;
    localparam logic [1:0] TIM_TIMA = 2'd1;
    localparam logic [1:0] TIM_TMA  = 2'd2;
    localparam logic [1:0] TIM_TAC  = 2'd3;

    // TAC field positions
    localparam int TAC_WIDTH   = 3;
    localparam int TAC_EN_BIT  = 2;
    localparam int TAC_SEL_MSB = 1;
    localparam int TAC_SEL_LSB = 0;

    typedef enum logic [1:0] {
        IDLE,
        OVF,
        RELOAD
    } tim_state_e;

    // Divider bit that clocks TIMA for each TAC clock-select value
    function automatic logic [3:0] tap_index(input logic [1:0] sel);
        case (sel)
            2'b00:   tap_index = 4'd9;
            2'b01:   tap_index = 4'd3;
            2'b10:   tap_index = 4'd5;
            default: tap_index = 4'd7;
        endcase
    endfunction

endpackage

// File: rtl/lr35902_timer_if.sv
// Register bus between the IO decoder (master) and the timer (slave).
interface lr35902_timer_if;
    logic       cs;
    logic [1:0] adr;
    logic [7:0] din;
    logic       write;
    logic [7:0] dout;
    logic       irq;

    modport master (output cs, adr, din, write, input dout, irq);
    modport slave  (input cs, adr, din, write, output dout, irq);
endinterface

// File: rtl/lr35902_timer_div.sv
// Free-running 16-bit divider with clear, TAC tap mux and tick falling-edge detect.
// Build option LR35902_TIMER_GLITCH_EN: when defined, any falling edge of the tick
// (including one caused by a DIV or TAC write) clocks TIMA; otherwise only natural
// divider carries do.
module lr35902_timer_div
    import lr35902_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr_i,
    input  logic                 tac_wr_i,
    input  logic [TAC_WIDTH-1:0] tac_i,
    output logic [7:0]           div_hi_o,
    output logic                 fall_o
);
    logic [15:0] div_q, div_d;
    logic        tick, tick_q;

    // Divider next value: a DIV write clears and suppresses the increment
    always_comb begin
        div_d = clr_i ? 16'h0000 : div_q + 16'd1;
    end

    assign tick     = tac_i[TAC_EN_BIT] & div_q[tap_index(tac_i[TAC_SEL_MSB:TAC_SEL_LSB])];
    assign div_hi_o = div_q[15:8];

    // Divider and previous-tick registers
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q  <= 16'h0000;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick;
        end
    end

`ifdef LR35902_TIMER_GLITCH_EN
    logic unused_tac_wr;
    assign unused_tac_wr = tac_wr_i;
    assign fall_o        = tick_q & ~tick;
`else
    logic wr_q;

    // Flags a tick change that was caused by a DIV/TAC write rather than a carry
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q <= 1'b0;
        end else begin
            wr_q <= clr_i | tac_wr_i;
        end
    end

    assign fall_o = tick_q & ~tick & ~wr_q;
`endif

endmodule

// File: rtl/lr35902_timer.sv
// DMG timer: DIV/TIMA/TMA/TAC registers, delayed TMA reload and one-cycle irq.
// Build option LR35902_TIMER_GLITCH_EN selects hardware-accurate spurious TIMA
// increments on DIV/TAC writes (see lr35902_timer_div).
//
// state  | meaning
// IDLE   | TIMA counts on tick falling edges
// OVF    | TIMA wrapped to 0x00; delay counter runs down to the reload cycle
// RELOAD | TIMA <= TMA, irq high for this cycle only
module lr35902_timer
    import lr35902_pkg::*;
#(
    parameter int RELOAD_DELAY = 4
) (
    input  logic           clk,
    input  logic           reset,
    lr35902_timer_if.slave bus
);
    localparam logic [2:0] DLY_INIT = 3'(RELOAD_DELAY - 1);

    logic [7:0]           tima_q, tima_d;
    logic [7:0]           tma_q, tma_d;
    logic [TAC_WIDTH-1:0] tac_q, tac_d;
    logic [2:0]           dly_q, dly_d;
    tim_state_e           state_q, state_d;
    logic [7:0]           div_hi;
    logic                 fall;
    logic                 wr_en, div_wr, tima_wr, tma_wr, tac_wr;

    assign wr_en   = bus.cs & bus.write;
    assign div_wr  = wr_en & (bus.adr == TIM_DIV);
    assign tima_wr = wr_en & (bus.adr == TIM_TIMA);
    assign tma_wr  = wr_en & (bus.adr == TIM_TMA);
    assign tac_wr  = wr_en & (bus.adr == TIM_TAC);

    lr35902_timer_div u_div (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (div_wr),
        .tac_wr_i (tac_wr),
        .tac_i    (tac_q),
        .div_hi_o (div_hi),
        .fall_o   (fall)
    );

    // Next-state and register update logic for the reload FSM
    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        tima_d  = tima_q;
        tma_d   = tma_wr ? bus.din : tma_q;
        tac_d   = tac_wr ? bus.din[TAC_WIDTH-1:0] : tac_q;
        case (state_q)
            IDLE: begin
                if (tima_wr) begin
                    tima_d = bus.din;
                end else if (fall) begin
                    if (tima_q == 8'hff) begin
                        tima_d  = 8'h00;
                        state_d = OVF;
                        dly_d   = DLY_INIT;
                    end else begin
                        tima_d = tima_q + 8'd1;
                    end
                end
            end
            OVF: begin
                if (tima_wr) begin
                    tima_d  = bus.din;
                    state_d = IDLE;
                end else begin
                    if (fall) tima_d = tima_q + 8'd1;
                    if (dly_q == 3'd0) state_d = RELOAD;
                    else               dly_d   = dly_q - 3'd1;
                end
            end
            RELOAD: begin
                tima_d  = tma_d;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and register file
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            dly_q   <= 3'd0;
            tima_q  <= 8'h00;
            tma_q   <= 8'h00;
            tac_q   <= '0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            tima_q  <= tima_d;
            tma_q   <= tma_d;
            tac_q   <= tac_d;
        end
    end

    assign bus.irq = (state_q == RELOAD);

    // Read mux; unselected reads float high like an open bus
    always_comb begin
        bus.dout = 8'hff;
        if (bus.cs) begin
            case (bus.adr)
                TIM_DIV:  bus.dout = div_hi;
                TIM_TIMA: bus.dout = tima_q;
                TIM_TMA:  bus.dout = tma_q;
                default:  bus.dout = {5'b11111, tac_q};
            endcase
        end
    end

endmodule
